// File: rtl/pipelined_adder.sv
// Pipelined ripple adder/subtractor with valid/ready flow control.
// The WIDTH-bit operation is split into STAGES equal segments. Each
// stage adds one segment using the carry registered by the stage before.
// The finished low segments and the still-unprocessed high operand bits
// move forward with each stage.
//
// Handshake: a transfer happens on a rising edge where valid && ready
// are both high. The whole pipeline advances when the output register is
// empty or is being drained (adv = !out_valid || out_ready). in_ready is
// that same advance term, so it never depends on in_valid.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    // Guarded stage count so that SEG stays computable even when the
    // parameter check below is about to reject the configuration.
    localparam int NSTG = (STAGES < 1) ? 1 : STAGES;
    localparam int SEG  = WIDTH / NSTG;

    if (WIDTH < 1 || WIDTH > 64 || STAGES < 1 || (WIDTH % NSTG) != 0) begin : g_bad_params
        $error("pipelined_adder: illegal WIDTH=%0d / STAGES=%0d combination", WIDTH, STAGES);
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    // Subtract is a + ~b + ~c_in. The final carry is then the no-borrow flag.
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub ? ~c_in : c_in;
    assign w_adv     = !out_valid || out_ready;
    assign in_ready  = w_adv;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        // Width of operand bits arriving at this stage, sum bits completed
        // after this stage, and operand bits still pending after it. The
        // final stage has no pending bits. It keeps only the operand sign
        // bits, which the overflow flag needs.
        localparam int SRC_W  = WIDTH - k * SEG;
        localparam int DONE_W = (k + 1) * SEG;
        localparam int HI_W   = (k == NSTG - 1) ? 1 : WIDTH - DONE_W;

        logic [SRC_W-1:0]  w_src_a;
        logic [SRC_W-1:0]  w_src_b;
        logic              w_src_c;
        logic              w_src_v;
        logic [SEG:0]      w_seg_sum;
        logic [DONE_W-1:0] w_sum_next;
        logic [HI_W-1:0]   w_hi_a_next;
        logic [HI_W-1:0]   w_hi_b_next;

        logic              r_v;
        logic              r_c;
        logic [DONE_W-1:0] r_sum;
        logic [HI_W-1:0]   r_hi_a;
        logic [HI_W-1:0]   r_hi_b;

        if (k == 0) begin : g_src
            assign w_src_a    = a;
            assign w_src_b    = w_b_eff;
            assign w_src_c    = w_cin_eff;
            assign w_src_v    = in_valid;
            assign w_sum_next = w_seg_sum[SEG-1:0];
        end else begin : g_src
            assign w_src_a    = g_stage[k-1].r_hi_a;
            assign w_src_b    = g_stage[k-1].r_hi_b;
            assign w_src_c    = g_stage[k-1].r_c;
            assign w_src_v    = g_stage[k-1].r_v;
            assign w_sum_next = {w_seg_sum[SEG-1:0], g_stage[k-1].r_sum};
        end

        if (k == NSTG - 1) begin : g_hi
            assign w_hi_a_next = w_src_a[SRC_W-1];
            assign w_hi_b_next = w_src_b[SRC_W-1];
        end else begin : g_hi
            assign w_hi_a_next = w_src_a[SRC_W-1:SEG];
            assign w_hi_b_next = w_src_b[SRC_W-1:SEG];
        end

        assign w_seg_sum = {1'b0, w_src_a[SEG-1:0]}
                         + {1'b0, w_src_b[SEG-1:0]}
                         + {{SEG{1'b0}}, w_src_c};

        // Stage register: valid moves on every advance, data only with a valid op.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v    <= 1'b0;
                r_c    <= 1'b0;
                r_sum  <= '0;
                r_hi_a <= '0;
                r_hi_b <= '0;
            end else if (w_adv) begin
                r_v <= w_src_v;
                if (w_src_v) begin
                    r_c    <= w_seg_sum[SEG];
                    r_sum  <= w_sum_next;
                    r_hi_a <= w_hi_a_next;
                    r_hi_b <= w_hi_b_next;
                end
            end
        end
    end

    assign out_valid = g_stage[NSTG-1].r_v;
    assign sum       = g_stage[NSTG-1].r_sum;
    assign c_out     = g_stage[NSTG-1].r_c;
    // Overflow occurs when the two addends have the same sign and the sum sign differs.
    // The output is all zero in reset, so this flag is 0 there too.
    assign ovf = (g_stage[NSTG-1].r_hi_a[0] == g_stage[NSTG-1].r_hi_b[0])
              && (sum[WIDTH-1] != g_stage[NSTG-1].r_hi_a[0]);

endmodule
